uart_prog_loader: RTL and testbench

- Parametrised successor to the fixed 16-bit UART program-memory loader feeding the CPU's instruction path.
- Receives a framed, checksummed program image over UART 8N1 and writes it into an internal word memory of INSTR_W x DEPTH.
- Serves synchronous instruction fetches to MAR/MDR and drives load_mode, which holds the CPU clock gate while loading.
- Adds framing, length and checksum validation with an error flag; the previous loader had none of these.

---
 rtl/uart_prog_loader_if.sv | 34 +++
 rtl/uart_prog_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// Fetch / status bus between the CPU core and the UART program loader.
// master = CPU side, slave = loader side.
interface uart_prog_loader_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 8
);
    logic                load_req;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [INSTR_W-1:0]  fetch_data;
    logic                load_mode;
    logic                load_done;
    logic                load_err;
    logic [ADDR_W:0]     word_count;

    modport master (
        output load_req,
        output fetch_addr,
        input  fetch_data,
        input  load_mode,
        input  load_done,
        input  load_err,
        input  word_count
    );

    modport slave (
        input  load_req,
        input  fetch_addr,
        output fetch_data,
        output load_mode,
        output load_done,
        output load_err,
        output word_count
    );
endinterface

// File: rtl/uart_prog_loader.sv
// UART 8N1 program loader: framed, checksummed image -> INSTR_W x DEPTH word memory,
// with a registered fetch port. Optional byte echo / ACK / NAK transmitter: LOADER_ECHO_EN.
module uart_prog_loader #(
    parameter int unsigned CLK_DIV  = 434,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              tx,
    uart_prog_loader_if.slave bus
);
    localparam int unsigned BYTES = INSTR_W / 8;
    localparam int unsigned CW    = $clog2(CLK_DIV + 1);
    localparam int unsigned MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CW-1:0]    BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] DEPTH_W  = CNT_W'(DEPTH);
    localparam logic [2:0]       LAST_IDX = 3'(BYTES - 1);

    // ---------------------------------------------------------------- RX front end
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_fall;

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_fall) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // Line back high at mid start bit: false start, drop silently.
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_state_d   = RxIdle;
                    byte_valid_d = rx_s2_q;
                    frame_err_d  = ~rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------------------------------------------------------- Loader FSM
    typedef enum logic [2:0] {StRun, StWaitHdr, StGetCnt, StGetData, StGetSum} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] word_count_q, target_q;
    logic [7:0]       sum_q;
    logic [2:0]       byte_idx_q;
    logic [INSTR_W-1:0] word_q, assembled;
    logic             err_q, done_q;
    logic             hdr_hit, cnt_take, data_take, mem_we, err_set, accept, load_mode;
    logic             n_too_big, last_byte, last_word, sum_ok;
    logic [CNT_W-1:0] n_target;

    assign n_too_big = {1'b0, rx_shift_q} > 9'(DEPTH);
    assign n_target  = (rx_shift_q == 8'd0) ? DEPTH_W : CNT_W'(rx_shift_q);
    assign last_byte = byte_idx_q == LAST_IDX;
    assign last_word = (word_count_q + CNT_W'(1)) == target_q;
    assign sum_ok    = rx_shift_q == sum_q;
    assign assembled = (word_q << 8) | INSTR_W'(rx_shift_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= StWaitHdr;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (bus.load_req) state_d = StWaitHdr;
            StWaitHdr: begin
                if (frame_err_q)                                state_d = StWaitHdr;
                else if (byte_valid_q && rx_shift_q == HDR_BYTE) state_d = StGetCnt;
            end
            StGetCnt: begin
                if (frame_err_q)       state_d = StWaitHdr;
                else if (byte_valid_q) state_d = n_too_big ? StWaitHdr : StGetData;
            end
            StGetData: begin
                if (frame_err_q)                                  state_d = StWaitHdr;
                else if (byte_valid_q && last_byte && last_word)  state_d = StGetSum;
            end
            StGetSum: begin
                if (frame_err_q)       state_d = StWaitHdr;
                else if (byte_valid_q) state_d = sum_ok ? StRun : StWaitHdr;
            end
            default: state_d = StWaitHdr;
        endcase
    end

    always_comb begin
        hdr_hit   = 1'b0;
        cnt_take  = 1'b0;
        data_take = 1'b0;
        mem_we    = 1'b0;
        err_set   = 1'b0;
        accept    = 1'b0;
        load_mode = state_q != StRun;
        unique case (state_q)
            StRun: ;
            StWaitHdr: begin
                if (frame_err_q)                                 err_set = 1'b1;
                else if (byte_valid_q && rx_shift_q == HDR_BYTE) hdr_hit = 1'b1;
            end
            StGetCnt: begin
                if (frame_err_q) err_set = 1'b1;
                else if (byte_valid_q) begin
                    err_set  = n_too_big;
                    cnt_take = ~n_too_big;
                end
            end
            StGetData: begin
                if (frame_err_q) err_set = 1'b1;
                else if (byte_valid_q) begin
                    data_take = 1'b1;
                    mem_we    = last_byte;
                end
            end
            StGetSum: begin
                if (frame_err_q) err_set = 1'b1;
                else if (byte_valid_q) begin
                    accept  = sum_ok;
                    err_set = ~sum_ok;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_q <= '0;
            target_q     <= '0;
            sum_q        <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= accept;
            if (hdr_hit) begin
                err_q        <= 1'b0;
                word_count_q <= '0;
                sum_q        <= '0;
                byte_idx_q   <= '0;
            end
            if (err_set) err_q <= 1'b1;
            if (cnt_take) begin
                target_q   <= n_target;
                sum_q      <= sum_q + rx_shift_q;
                byte_idx_q <= '0;
            end
            if (data_take) begin
                sum_q      <= sum_q + rx_shift_q;
                word_q     <= assembled;
                byte_idx_q <= last_byte ? 3'd0 : byte_idx_q + 1'b1;
                if (last_byte) word_count_q <= word_count_q + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- Memory / fetch
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] fetch_data_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[word_count_q[MAW-1:0]] <= assembled;
    end

    // Non-blocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset)                               fetch_data_q <= '0;
        else if ({1'b0, bus.fetch_addr} < DEPTH_W) fetch_data_q <= mem[bus.fetch_addr[MAW-1:0]];
        else                                     fetch_data_q <= '0;
    end

    assign bus.fetch_data = fetch_data_q;
    assign bus.load_mode  = load_mode;
    assign bus.load_done  = done_q;
    assign bus.load_err   = err_q;
    assign bus.word_count = word_count_q;

    // ---------------------------------------------------------------- Echo transmitter
`ifdef LOADER_ECHO_EN
    logic          tx_busy_q, tx_busy_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic          buf_vld_q, buf_vld_d, resp_vld_q, resp_vld_d;
    logic [7:0]    buf_q, buf_d, resp_q, resp_d;
    logic          echo_ev, echo_used, start;
    logic [7:0]    start_byte;

    assign echo_ev = byte_valid_q && (state_q != StRun);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            buf_vld_q  <= 1'b0;
            buf_q      <= '0;
            resp_vld_q <= 1'b0;
            resp_q     <= '0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bits_q  <= tx_bits_d;
            buf_vld_q  <= buf_vld_d;
            buf_q      <= buf_d;
            resp_vld_q <= resp_vld_d;
            resp_q     <= resp_d;
        end
    end

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_d      = buf_q;
        resp_vld_d = resp_vld_q;
        resp_d     = resp_q;
        start      = 1'b0;
        start_byte = 8'h00;
        echo_used  = 1'b0;
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bits_d  = tx_bits_q;
        // ACK/NAK waits in its own slot so it always follows the echo of the last byte.
        if (accept || err_set) begin
            resp_vld_d = 1'b1;
            resp_d     = accept ? 8'h06 : 8'h15;
        end
        if (!tx_busy_q) begin
            if (buf_vld_q) begin
                start      = 1'b1;
                start_byte = buf_q;
                buf_vld_d  = 1'b0;
            end else if (echo_ev) begin
                start      = 1'b1;
                start_byte = rx_shift_q;
                echo_used  = 1'b1;
            end else if (resp_vld_q) begin
                start      = 1'b1;
                start_byte = resp_q;
                resp_vld_d = accept || err_set;
            end
        end
        if (echo_ev && !echo_used && !buf_vld_d) begin
            buf_vld_d = 1'b1;
            buf_d     = rx_shift_q;
        end
        if (start) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, start_byte, 1'b0};
            tx_cnt_d   = '0;
            tx_bits_d  = '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_END) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                if (tx_bits_q == 4'd9) tx_busy_d = 1'b0;
                else                   tx_bits_d = tx_bits_q + 1'b1;
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    assign tx = tx_busy_q ? tx_shift_q[0] : 1'b1;
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: UART frames driven at CLK_DIV=4, fetch port
// checked from a vector table.
module tb_uart_prog_loader;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic tx;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_mode_bad = 0;
    int tx_low   = 0;

    uart_prog_loader_if #(.INSTR_W(16), .ADDR_W(8)) bus ();

    uart_prog_loader #(
        .CLK_DIV (CD),
        .INSTR_W (16),
        .ADDR_W  (8),
        .DEPTH   (256),
        .HDR_BYTE(8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .tx   (tx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && bus.load_done) begin
            done_cnt = done_cnt + 1;
            if (bus.load_mode !== 1'b0) done_mode_bad = done_mode_bad + 1;
        end
        if (tx !== 1'b1) tx_low = tx_low + 1;
    end

    typedef struct {
        int          phase;
        logic [7:0]  addr;
        logic [15:0] exp;
    } fvec_t;

    fvec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (CD - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx = b[i];
            repeat (CD - 1) @(negedge clk);
        end
        @(negedge clk) rx = stop;
        repeat (CD - 1) @(negedge clk);
        @(negedge clk) rx = 1'b1;
        repeat (2 * CD) @(negedge clk);
    endtask

    // Sends f followed by the checksum of f[1..]; bad_stop_idx >= 0 ends the frame early
    // with a zero stop bit on that byte.
    task automatic send_frame(input logic [7:0] f[$], input bit bad_sum, input int bad_stop_idx);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 1; i < f.size(); i++) sum = sum + f[i];
        if (bad_sum) sum = sum + 8'h01;
        for (int i = 0; i < f.size(); i++) begin
            if (i == bad_stop_idx) begin
                send_byte(f[i], 1'b0);
                return;
            end
            send_byte(f[i], 1'b1);
        end
        send_byte(sum, 1'b1);
    endtask

    task automatic enter_load(input string name);
        @(negedge clk) bus.load_req = 1'b1;
        @(negedge clk) chk(name, 32'(bus.load_mode), 32'd1);
        bus.load_req = 1'b0;
    endtask

    task automatic run_table(input int phase);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].phase == phase) begin
                @(negedge clk) bus.fetch_addr = tbl[i].addr;
                @(negedge clk);
                chk($sformatf("fetch_p%0d_a%0d", phase, tbl[i].addr),
                    32'(bus.fetch_data), 32'(tbl[i].exp));
            end
        end
    endtask

    initial begin
        logic [7:0] f[$];
        int d0;

        tbl[0] = '{1, 8'd0,   16'h1234};
        tbl[1] = '{1, 8'd1,   16'hABCD};
        tbl[2] = '{3, 8'd0,   16'hCAFE};
        tbl[3] = '{3, 8'd1,   16'hBEEF};
        tbl[4] = '{4, 8'd0,   16'h5566};
        tbl[5] = '{4, 8'd1,   16'hBEEF};
        tbl[6] = '{5, 8'd0,   16'h0101};
        tbl[7] = '{5, 8'd1,   16'h0101};
        tbl[8] = '{5, 8'd128, 16'h0101};
        tbl[9] = '{5, 8'd255, 16'h0101};

        reset = 1'b1;
        rx = 1'b1;
        bus.load_req = 1'b0;
        bus.fetch_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_load_mode",  32'(bus.load_mode),  32'd1);
        chk("rst_load_done",  32'(bus.load_done),  32'd0);
        chk("rst_load_err",   32'(bus.load_err),   32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        chk("rst_tx",         32'(tx),             32'd1);
        chk("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);

        // Basic two-word image
        d0 = done_cnt;
        f = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(f, 1'b0, -1);
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t1_mode_at_done", 32'(done_mode_bad), 32'd0);
        chk("t1_load_mode", 32'(bus.load_mode), 32'd0);
        chk("t1_load_err",  32'(bus.load_err),  32'd0);
        chk("t1_word_count", 32'(bus.word_count), 32'd2);
        run_table(1);

        // Bytes in RUN are ignored
        send_byte(8'hA5, 1'b1);
        chk("run_ignore_mode", 32'(bus.load_mode), 32'd0);
        chk("run_ignore_err",  32'(bus.load_err),  32'd0);

        // Bad checksum, then good resend
        enter_load("t2_enter");
        d0 = done_cnt;
        send_frame(f, 1'b1, -1);
        chk("t2_bad_err",   32'(bus.load_err),    32'd1);
        chk("t2_bad_mode",  32'(bus.load_mode),   32'd1);
        chk("t2_bad_done",  32'(done_cnt - d0),   32'd0);
        send_frame(f, 1'b0, -1);
        chk("t2_good_err",  32'(bus.load_err),    32'd0);
        chk("t2_good_done", 32'(done_cnt - d0),   32'd1);
        chk("t2_good_mode", 32'(bus.load_mode),   32'd0);

        // Garbage and a one-cycle glitch ahead of a valid frame
        enter_load("t3_enter");
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (3 * CD) @(negedge clk);
        chk("t3_garbage_err",  32'(bus.load_err),  32'd0);
        chk("t3_garbage_mode", 32'(bus.load_mode), 32'd1);
        d0 = done_cnt;
        f = {8'hA5, 8'h02, 8'hCA, 8'hFE, 8'hBE, 8'hEF};
        send_frame(f, 1'b0, -1);
        chk("t3_done", 32'(done_cnt - d0), 32'd1);
        chk("t3_err",  32'(bus.load_err),  32'd0);
        run_table(3);

        // Framing error on the third data byte
        enter_load("t4_enter");
        d0 = done_cnt;
        f = {8'hA5, 8'h02, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(f, 1'b0, 4);
        chk("t4_err",        32'(bus.load_err),   32'd1);
        chk("t4_mode",       32'(bus.load_mode),  32'd1);
        chk("t4_word_count", 32'(bus.word_count), 32'd1);
        chk("t4_done",       32'(done_cnt - d0),  32'd0);
        run_table(4);

        // N=0 -> full DEPTH image; sent without load_req, so FSM must be back in WAIT_HDR
        d0 = done_cnt;
        f = {8'hA5, 8'h00};
        for (int i = 0; i < 512; i++) f.push_back(8'h01);
        send_frame(f, 1'b0, -1);
        chk("t5_done",       32'(done_cnt - d0),  32'd1);
        chk("t5_err",        32'(bus.load_err),   32'd0);
        chk("t5_word_count", 32'(bus.word_count), 32'd256);
        chk("t5_mode",       32'(bus.load_mode),  32'd0);
        run_table(5);
        enter_load("t5_reload");

`ifndef LOADER_ECHO_EN
        chk("tx_stays_idle", 32'(tx_low), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
